// File: rtl/unidade_busca.sv
// unidade_busca: instruction fetch unit with a prefetch queue.
// Optional `CONTADOR_DESCARTE_EN adds the dropped-response/flush counter.
module unidade_busca #(
  parameter int          PROFUNDIDADE     = 4,
  parameter logic [31:0] ENDERECO_INICIAL = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_endereco,
  input  logic        mem_ack,
  input  logic [31:0] mem_dado,
  input  logic        desvio,
  input  logic [31:0] endereco_desvio,
  output logic        instr_valida,
  output logic [31:0] instrucao,
  output logic [31:0] pc_instr,
`ifdef CONTADOR_DESCARTE_EN
  input  logic        instr_pronta,
  output logic [15:0] contador_descarte
`else
  input  logic        instr_pronta
`endif
);

  localparam int PW = $clog2(PROFUNDIDADE);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    OCIOSO,
    BUSCA,
    DESCARTE
  } estado_t;

  estado_t     r_estado;
  logic        r_req;
  logic [31:0] r_end;
  logic [31:0] r_alvo;

  logic [31:0] r_fila_dado [PROFUNDIDADE];
  logic [31:0] r_fila_pc   [PROFUNDIDADE];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_ocup;

  logic [31:0]   w_alvo;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_ocup_prox;
  logic          w_espaco;

  assign w_alvo      = endereco_desvio & 32'hFFFF_FFFC;
  assign w_push      = (r_estado == BUSCA) && mem_ack && !desvio;
  assign w_pop       = (r_ocup != '0) && instr_pronta && !desvio;
  assign w_ocup_prox = r_ocup + CW'(w_push) - CW'(w_pop);
  assign w_espaco    = w_ocup_prox < CW'(PROFUNDIDADE);

  assign mem_req      = r_req;
  assign mem_endereco = r_end;
  assign instr_valida = (r_ocup != '0);
  assign instrucao    = r_fila_dado[r_rd];
  assign pc_instr     = r_fila_pc[r_rd];

  // Request FSM: one outstanding request, redirect drops stale response
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado <= OCIOSO;
      r_req    <= 1'b0;
      r_end    <= ENDERECO_INICIAL;
      r_alvo   <= ENDERECO_INICIAL;
    end else begin
      unique case (r_estado)
        OCIOSO: begin
          if (desvio) begin
            r_end <= w_alvo;
          end else if (w_espaco) begin
            r_req    <= 1'b1;
            r_estado <= BUSCA;
          end
        end
        BUSCA: begin
          if (desvio) begin
            if (mem_ack) begin
              r_end <= w_alvo;
            end else begin
              r_alvo   <= w_alvo;
              r_estado <= DESCARTE;
            end
          end else if (mem_ack) begin
            r_end <= r_end + 32'd4;
            if (!w_espaco) begin
              r_req    <= 1'b0;
              r_estado <= OCIOSO;
            end
          end
        end
        DESCARTE: begin
          if (mem_ack) begin
            r_end    <= desvio ? w_alvo : r_alvo;
            r_estado <= BUSCA;
          end else if (desvio) begin
            r_alvo <= w_alvo;
          end
        end
        default: begin
          r_req    <= 1'b0;
          r_estado <= OCIOSO;
        end
      endcase
    end
  end

  // Prefetch queue: redirect flushes, otherwise push/pop by occupancy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PROFUNDIDADE; i++) begin
        r_fila_dado[i] <= '0;
        r_fila_pc[i]   <= '0;
      end
      r_rd   <= '0;
      r_wr   <= '0;
      r_ocup <= '0;
    end else if (desvio) begin
      r_rd   <= '0;
      r_wr   <= '0;
      r_ocup <= '0;
    end else begin
      if (w_push) begin
        r_fila_dado[r_wr] <= mem_dado;
        r_fila_pc[r_wr]   <= r_end;
        r_wr              <= r_wr + PW'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + PW'(1);
      end
      r_ocup <= w_ocup_prox;
    end
  end

`ifdef CONTADOR_DESCARTE_EN
  logic [15:0] r_descarte;
  logic [16:0] w_soma;
  logic [CW:0] w_inc;
  logic        w_drop;

  assign w_drop = mem_ack &&
                  ((r_estado == DESCARTE) ||
                   ((r_estado == BUSCA) && desvio));
  assign w_inc  = (desvio ? {1'b0, r_ocup} : '0) + (CW+1)'(w_drop);
  assign w_soma = {1'b0, r_descarte} + 17'(w_inc);
  assign contador_descarte = r_descarte;

  // Saturating count of dropped responses and flushed entries
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_descarte <= '0;
    end else begin
      r_descarte <= w_soma[16] ? 16'hFFFF : w_soma[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_unidade_busca.sv
// tb_unidade_busca: directed + random checks of unidade_busca
// against a queue-level reference model and a behavioural memory.
module tb_unidade_busca;

  localparam int          PROF = 4;
  localparam logic [31:0] INI  = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req;
  logic [31:0] mem_endereco;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_dado = '0;
  logic        desvio = 1'b0;
  logic [31:0] endereco_desvio = '0;
  logic        instr_valida;
  logic [31:0] instrucao;
  logic [31:0] pc_instr;
  logic        instr_pronta = 1'b0;
`ifdef CONTADOR_DESCARTE_EN
  logic [15:0] contador_descarte;
`endif

  unidade_busca #(
    .PROFUNDIDADE(PROF),
    .ENDERECO_INICIAL(INI)
  ) dut (
    .clock(clock),
    .reset(reset),
    .mem_req(mem_req),
    .mem_endereco(mem_endereco),
    .mem_ack(mem_ack),
    .mem_dado(mem_dado),
    .desvio(desvio),
    .endereco_desvio(endereco_desvio),
    .instr_valida(instr_valida),
    .instrucao(instrucao),
    .pc_instr(pc_instr),
`ifdef CONTADOR_DESCARTE_EN
    .instr_pronta(instr_pronta),
    .contador_descarte(contador_descarte)
`else
    .instr_pronta(instr_pronta)
`endif
  );

  always #5 clock = ~clock;

  int ncomp = 0;
  int nfail = 0;

  logic [31:0] q_pc[$];
  logic [31:0] pops[$];
  logic [31:0] caps[$];
  logic [31:0] fetch_exp;
  logic [31:0] end_cur;
  bit          busy;
  bit          drop;
  int          espera;
  int          lat;
  int          ncapt;
  int          exp_cont;
  bit          feito;

  function automatic logic [31:0] f(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sense();
    chk("valida", 32'(instr_valida), 32'(q_pc.size() > 0));
    if (q_pc.size() > 0) begin
      chk("pc_instr", pc_instr, q_pc[0]);
      chk("instrucao", instrucao, f(q_pc[0]));
    end
`ifdef CONTADOR_DESCARTE_EN
    chk("contador", 32'(contador_descarte), 32'(exp_cont));
`endif
    if (mem_ack) begin
      mem_ack = 1'b0;
      busy = 1'b0;
    end
    mem_dado = $urandom;
    if (busy) begin
      chk("req_estavel", 32'(mem_req), 32'd1);
      chk("end_estavel", mem_endereco, end_cur);
      if (espera > 0) espera--;
      if (espera == 0) begin
        mem_ack = 1'b1;
        mem_dado = f(end_cur);
      end
    end else if (mem_req) begin
      busy = 1'b1;
      drop = 1'b0;
      end_cur = mem_endereco;
      chk("end_req", mem_endereco, fetch_exp);
      fetch_exp = fetch_exp + 32'd4;
      caps.push_back(end_cur);
      ncapt++;
      espera = lat;
      if (espera == 0) begin
        mem_ack = 1'b1;
        mem_dado = f(end_cur);
      end
    end
  endtask

  task automatic commit();
    bit pop_m;
    bit acc;
    pop_m = (q_pc.size() > 0) && instr_pronta && !desvio;
    acc = mem_ack && !drop && !desvio;
    if (desvio) exp_cont += q_pc.size();
    if (mem_ack && (drop || desvio)) exp_cont++;
    if (exp_cont > 65535) exp_cont = 65535;
    if (desvio) begin
      q_pc.delete();
      fetch_exp = endereco_desvio & 32'hFFFF_FFFC;
      if (busy && !mem_ack) drop = 1'b1;
    end else begin
      if (pop_m) begin
        pops.push_back(q_pc[0]);
        void'(q_pc.pop_front());
      end
      if (acc) q_pc.push_back(end_cur);
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic ciclo(input bit p, input bit d, input logic [31:0] t);
    sense();
    instr_pronta = p;
    desvio = d;
    endereco_desvio = t;
    commit();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_end", mem_endereco, INI);
    chk("rst_valida", 32'(instr_valida), 32'd0);
    chk("rst_instrucao", instrucao, 32'd0);
    chk("rst_pc", pc_instr, 32'd0);
`ifdef CONTADOR_DESCARTE_EN
    chk("rst_contador", 32'(contador_descarte), 32'd0);
`endif
    q_pc.delete();
    pops.delete();
    caps.delete();
    busy = 1'b0;
    drop = 1'b0;
    mem_ack = 1'b0;
    desvio = 1'b0;
    instr_pronta = 1'b0;
    fetch_exp = INI;
    exp_cont = 0;
    ncapt = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    @(negedge clock);

    // reset release, streaming with single-cycle memory
    lat = 0;
    do_reset();
    ciclo(1, 0, 0);
    chk("req_apos_reset", 32'(mem_req), 32'd1);
    repeat (8) ciclo(1, 0, 0);
    chk("n_pops_stream", 32'(pops.size() >= 4), 32'd1);
    if (pops.size() >= 4) begin
      chk("stream0", pops[0], 32'h0);
      chk("stream1", pops[1], 32'h4);
      chk("stream2", pops[2], 32'h8);
      chk("stream3", pops[3], 32'hC);
    end

    // consumer stalled: queue fills, then one pop refills one slot
    do_reset();
    repeat (10) ciclo(0, 0, 0);
    chk("n_req_cheio", 32'(ncapt), 32'd4);
    chk("req_parado", 32'(mem_req), 32'd0);
    ciclo(1, 0, 0);
    repeat (6) ciclo(0, 0, 0);
    chk("n_req_pop", 32'(ncapt), 32'd5);
    chk("req_parado2", 32'(mem_req), 32'd0);

    // redirect while a slow request is outstanding
    lat = 3;
    do_reset();
    ciclo(1, 0, 0);
    ciclo(1, 1, 32'h0000_0103);
    repeat (14) ciclo(1, 0, 0);
    chk("n_caps_desc", 32'(caps.size() >= 2), 32'd1);
    if (caps.size() >= 2) chk("end_alvo", caps[1], 32'h100);
    chk("n_pops_desc", 32'(pops.size() >= 1), 32'd1);
    if (pops.size() >= 1) chk("pc_alvo", pops[0], 32'h100);

    // redirect coincident with ack while queue holds three entries
    lat = 0;
    do_reset();
    feito = 1'b0;
    for (int i = 0; i < 20 && !feito; i++) begin
      sense();
      instr_pronta = 1'b0;
      desvio = 1'b0;
      if (q_pc.size() == 3 && mem_ack) begin
        desvio = 1'b1;
        endereco_desvio = 32'h0000_0040;
        feito = 1'b1;
      end
      commit();
    end
    chk("alcancou_3", 32'(feito), 32'd1);
    chk("valida_pos_flush", 32'(instr_valida), 32'd0);
`ifdef CONTADOR_DESCARTE_EN
    chk("contador_flush", 32'(contador_descarte), 32'd4);
`endif
    repeat (6) ciclo(1, 0, 0);
    chk("n_pops_flush", 32'(pops.size() >= 1), 32'd1);
    if (pops.size() >= 1) chk("pc_pos_flush", pops[0], 32'h40);

    // redirect to the last word: address wraps to zero
    do_reset();
    repeat (3) ciclo(1, 0, 0);
    pops.delete();
    ciclo(1, 1, 32'hFFFF_FFFC);
    repeat (6) ciclo(1, 0, 0);
    chk("n_pops_wrap", 32'(pops.size() >= 2), 32'd1);
    if (pops.size() >= 2) begin
      chk("wrap0", pops[0], 32'hFFFF_FFFC);
      chk("wrap1", pops[1], 32'h0);
    end

    // reset between request and ack
    lat = 3;
    do_reset();
    repeat (3) ciclo(1, 0, 0);
    chk("req_pendente", 32'(mem_req), 32'd1);
    lat = 0;
    do_reset();
    repeat (6) ciclo(1, 0, 0);
    chk("n_caps_rst", 32'(caps.size() >= 1), 32'd1);
    if (caps.size() >= 1) chk("refetch_ini", caps[0], INI);
    chk("n_pops_rst", 32'(pops.size() >= 1), 32'd1);
    if (pops.size() >= 1) chk("refetch_pc", pops[0], INI);

    // randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      lat = $urandom_range(0, 3);
      t = ($urandom_range(0, 3) == 0) ?
          (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      ciclo(($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0), t);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
